pipelined_rc_adder: RTL and testbench
=====================================

# pipelined_rc_adder

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. It adds or subtracts two WIDTH-bit operands and splits the carry chain into STAGES registered ripple slices, each WIDTH/STAGES bits wide. A valid/ready handshake on both sides lets it sit between streaming datapath blocks with full backpressure, at one result per cycle. It also produces carry-in, carry/no-borrow and signed-overflow flags.

## Interface
- WIDTH, 16: operand and result width in bits; must be ≥ 2.
- STAGES, 4: number of pipeline slices; ≥ 1, and WIDTH % STAGES == 0. Slice width is SW = WIDTH/STAGES.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- A  input  WIDTH  operand A, unsigned or two's complement.
- B  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result.
- carry  output  1  add: carry-out; sub: no-borrow (1 when A ≥ B + cin, unsigned).
- overflow  output  1  signed two's-complement overflow of the operation.

## Operation
- Add: {carry,sum} = A + B + cin.
- Sub: {carry,sum} = A + ~B + ~cin, which equals A − B − cin modulo 2^WIDTH.
- overflow = (opA[W-1] == opB'[W-1]) && (sum[W-1] != opA[W-1]), where opB' is the inverted B in sub mode.
- Slice k (0 = LSB) adds bits [k·SW +: SW] with a full-adder ripple. Its carry-in is the carry registered by slice k−1. Slice 0 uses cin, or ~cin in sub mode.
- Pipeline register k holds:
  - valid bit v[k]
  - completed low sum bits
  - registered carry
  - the not-yet-consumed upper bits of A and B' (B' = B already conditioned for sub)
  - the MSB signs needed for overflow
- Elastic handshake:
  - rdy[STAGES] = out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0].
  - Register k loads when rdy[k]; it takes the upstream valid, which is in_valid for k = 0.
  - in_ready is a combinational function of out_ready and the valid bits. No bubble is inserted at full occupancy.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- out_valid = v[STAGES−1]. sum, carry and overflow come directly from the last register.
- Stalled stages hold all contents unchanged. sum, carry and overflow hold their last value when out_valid = 0.
- Beats never reorder, drop or duplicate. Capacity is exactly STAGES beats.
- in_valid may drop without a transfer. Operands are sampled only on a transfer.

## Timing
- Reset (async assert, sampled deassert on clk):
  - all v[k] = 0
  - out_valid = 0, sum = 0, carry = 0, overflow = 0
  - in_ready = 1 while rst is high and after release
- Reset asserted mid-operation discards all in-flight beats immediately, with no partial output.
- Latency: a beat transferred at rising edge t is presented with out_valid = 1 immediately after edge t + STAGES − 1. This is STAGES edges counting the capture edge. With STAGES = 4, the beat accepted at edge 0 is valid after edge 3.
- Throughput: one beat per cycle while out_ready = 1.
- Simultaneous output and input transfer when full: both occur in the same cycle and occupancy is unchanged.
- out_ready = 0 with the pipeline full: in_ready = 0 in that same cycle.
- Critical path per stage is an SW-bit ripple plus the register. The in_ready path spans STAGES AND/OR levels from out_ready.

## Test plan
- WIDTH=16, STAGES=4, add, 0xFFFF + 0x0001, cin=0 -> after 4 edges: sum=0x0000, carry=1, overflow=0.
- Add 0x7FFF + 0x0000 with cin=1 -> sum=0x8000, carry=0, overflow=1. Then sub 0x0005 − 0x0007, cin=0 -> sum=0xFFFE, carry=0, overflow=0.
- Sub 0x8000 − 0x0001, cin=0 -> sum=0x7FFF, carry=1, overflow=1. Sub 0x0010 − 0x0003, cin=1 -> sum=0x000C, carry=1.
- Stream 10 back-to-back beats with random operands while out_ready is low for 3 cycles mid-stream:
  - in_ready falls once 4 beats are held
  - all 10 results emerge in order and match the reference model
  - sum, carry and overflow hold during the stall
- Load 3 beats, then assert rst asynchronously between edges -> out_valid=0, sum=0 and in_ready=1 immediately. No stale beat appears after release.
- STAGES=1, WIDTH=8: 0xC8 + 0x64 -> sum=0x2C, carry=1, overflow=0 after 1 edge. STAGES=16, WIDTH=16: randomised 1000-beat soak against the model with random backpressure.

Source files
------------

// File: rtl/pipelined_rc_adder_if.sv
// ---------------------------------------------------------------------------
// pipelined_rc_adder_if
//
// Purpose: groups the operand-side and result-side valid/ready streams of the
// pipelined ripple-carry adder into one bundle.
//
// Signals:
//   in_valid  - operand beat present (upstream -> adder)
//   in_ready  - adder accepts the operand beat this cycle (adder -> upstream)
//   A, B      - WIDTH-bit operands
//   cin       - carry-in for add, borrow-in for subtract
//   sub       - 0 = add, 1 = subtract
//   out_valid - result beat present (adder -> downstream)
//   out_ready - downstream accepts the result (downstream -> adder)
//   sum       - WIDTH-bit result
//   carry     - carry-out (add) or no-borrow (subtract)
//   overflow  - signed two's-complement overflow
//
// Modports:
//   master - the environment around the adder (drives operands and out_ready)
//   slave  - the adder itself
// ---------------------------------------------------------------------------
interface pipelined_rc_adder_if #(
    parameter int WIDTH = 16
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid,
        output A,
        output B,
        output cin,
        output sub,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  carry,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  A,
        input  B,
        input  cin,
        input  sub,
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output carry,
        output overflow
    );

endinterface

// File: rtl/pipelined_rc_adder.sv
// ---------------------------------------------------------------------------
// pipelined_rc_adder
//
// Purpose: WIDTH-bit add/subtract unit whose carry chain is cut into STAGES
// registered ripple slices of SW = WIDTH/STAGES bits. Slice k adds operand
// bits [k*SW +: SW] using the carry registered by slice k-1, so each stage's
// critical path is one SW-bit ripple. An elastic valid/ready pipeline gives
// full backpressure at one beat per cycle and holds exactly STAGES beats.
//
// Parameters:
//   WIDTH  - operand/result width (>= 2)
//   STAGES - number of pipeline slices (>= 1, WIDTH % STAGES == 0)
//
// Ports:
//   clk - single clock, rising edge
//   rst - asynchronous, active-high reset; discards every in-flight beat
//   io  - pipelined_rc_adder_if.slave (operand stream in, result stream out)
//
// Flags:
//   carry    - add: carry-out; sub: no-borrow (A >= B + cin, unsigned)
//   overflow - signed overflow, evaluated on A and the conditioned B'
// ---------------------------------------------------------------------------
module pipelined_rc_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_rc_adder_if.slave    io
);

    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // One full-adder cell: returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(
        input logic a,
        input logic b,
        input logic c
    );
        logic s_v;
        logic co_v;
        s_v  = a ^ b ^ c;
        co_v = (a & b) | (c & (a ^ b));
        return {co_v, s_v};
    endfunction

    // ------------------------------------------------------------------
    // Pipeline registers. Register k holds the beat after slice k has run:
    // the sum bits completed so far, the carry into slice k+1, and the
    // operands (A and already-conditioned B') whose upper bits are still
    // to be consumed. The operand MSBs travel along for the overflow flag.
    // ------------------------------------------------------------------
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic              overflow_q;
    logic              overflow_d;

    // Upstream view of every stage (stage 0 sees the input port).
    logic [STAGES-1:0] src_v_s;
    logic [WIDTH-1:0]  src_a_s   [STAGES];
    logic [WIDTH-1:0]  src_b_s   [STAGES];
    logic [WIDTH-1:0]  src_sum_s [STAGES];
    logic [STAGES-1:0] src_c_s;

    // Result of running each stage's slice on its upstream beat.
    logic [WIDTH-1:0]  slice_sum_s [STAGES];
    logic [STAGES-1:0] slice_c_s;
    logic              slice_ovf_s;

    // Stage k may load this cycle.
    logic [STAGES-1:0] rdy_s;

    // Select each stage's upstream source; stage 0 conditions B and cin for subtract.
    always_comb begin
        src_v_s      = {STAGES{1'b0}};
        src_c_s      = {STAGES{1'b0}};
        src_v_s[0]   = io.in_valid;
        src_a_s[0]   = io.A;
        src_b_s[0]   = io.sub ? ~io.B : io.B;
        src_sum_s[0] = {WIDTH{1'b0}};
        src_c_s[0]   = io.sub ? ~io.cin : io.cin;
        for (int k = 1; k < STAGES; k++) begin
            src_v_s[k]   = v_q[k-1];
            src_a_s[k]   = a_q[k-1];
            src_b_s[k]   = b_q[k-1];
            src_sum_s[k] = sum_q[k-1];
            src_c_s[k]   = carry_q[k-1];
        end
    end

    // Ripple each stage's SW-bit slice and evaluate overflow on the MSB slice.
    always_comb begin
        logic       c_v;
        logic [1:0] fa_v;
        logic [WIDTH-1:0] acc_v;
        c_v       = 1'b0;
        fa_v      = 2'b00;
        acc_v     = {WIDTH{1'b0}};
        slice_c_s = {STAGES{1'b0}};
        for (int k = 0; k < STAGES; k++) begin
            c_v   = src_c_s[k];
            acc_v = src_sum_s[k];
            for (int i = 0; i < SW; i++) begin
                fa_v = full_add(src_a_s[k][k*SW+i], src_b_s[k][k*SW+i], c_v);
                acc_v[k*SW+i] = fa_v[0];
                c_v           = fa_v[1];
            end
            slice_sum_s[k] = acc_v;
            slice_c_s[k]   = c_v;
        end
        // Same-sign operands producing a result of the other sign.
        slice_ovf_s = (src_a_s[LAST][WIDTH-1] == src_b_s[LAST][WIDTH-1]) &&
                      (slice_sum_s[LAST][WIDTH-1] != src_a_s[LAST][WIDTH-1]);
    end

    // Backward ready chain: a stage can load if it is empty or its successor can.
    always_comb begin
        logic r_v;
        r_v   = io.out_ready;
        rdy_s = {STAGES{1'b0}};
        for (int k = LAST; k >= 0; k--) begin
            r_v      = !v_q[k] || r_v;
            rdy_s[k] = r_v;
        end
    end

    // Next-state: valid bits follow upstream on load; data loads only with a real beat.
    always_comb begin
        v_d        = v_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]   = a_q[k];
            b_d[k]   = b_q[k];
            sum_d[k] = sum_q[k];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (rdy_s[k]) begin
                v_d[k] = src_v_s[k];
            end else begin
                v_d[k] = v_q[k];
            end
            // Data only moves with a valid beat, so outputs hold across bubbles.
            if (rdy_s[k] && src_v_s[k]) begin
                a_d[k]     = src_a_s[k];
                b_d[k]     = src_b_s[k];
                sum_d[k]   = slice_sum_s[k];
                carry_d[k] = slice_c_s[k];
            end else begin
                a_d[k]     = a_q[k];
                b_d[k]     = b_q[k];
                sum_d[k]   = sum_q[k];
                carry_d[k] = carry_q[k];
            end
        end
        if (rdy_s[LAST] && src_v_s[LAST]) begin
            overflow_d = slice_ovf_s;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Pipeline state; reset empties every stage and clears the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q        <= {STAGES{1'b0}};
            carry_q    <= {STAGES{1'b0}};
            overflow_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= {WIDTH{1'b0}};
                b_q[k]   <= {WIDTH{1'b0}};
                sum_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            v_q        <= v_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    // in_ready is combinational so a full pipeline still accepts when it drains.
    assign io.in_ready  = rdy_s[0];
    assign io.out_valid = v_q[LAST];
    assign io.sum       = sum_q[LAST];
    assign io.carry     = carry_q[LAST];
    assign io.overflow  = overflow_q;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
module tb_pipelined_rc_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_rc_adder_if #(.WIDTH(16)) bus4  ();
    pipelined_rc_adder_if #(.WIDTH(8))  bus1  ();
    pipelined_rc_adder_if #(.WIDTH(16)) bus16 ();

    pipelined_rc_adder #(.WIDTH(16), .STAGES(4))  dut4  (.clk(clk), .rst(rst), .io(bus4));
    pipelined_rc_adder #(.WIDTH(8),  .STAGES(1))  dut1  (.clk(clk), .rst(rst), .io(bus1));
    pipelined_rc_adder #(.WIDTH(16), .STAGES(16)) dut16 (.clk(clk), .rst(rst), .io(bus16));

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [17:0] model16(input logic [15:0] a, input logic [15:0] b,
                                            input logic ci, input logic s);
        logic [16:0] r;
        logic        ovf;
        logic        cy;
        if (s) begin
            r   = {1'b0, a} - {1'b0, b} - {16'd0, ci};
            cy  = ~r[16];
            ovf = (a[15] != b[15]) && (r[15] != a[15]);
        end else begin
            r   = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            cy  = r[16];
            ovf = (a[15] == b[15]) && (r[15] != a[15]);
        end
        return {ovf, cy, r[15:0]};
    endfunction

    // One beat through the 4-stage unit, checking latency, result and hold.
    task automatic directed4(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic s,
                             input logic [15:0] es, input logic ec, input logic eo);
        @(negedge clk);
        bus4.A = a; bus4.B = b; bus4.cin = ci; bus4.sub = s;
        bus4.in_valid = 1'b1; bus4.out_ready = 1'b1;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_early"}, 32'(bus4.out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(bus4.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus4.sum),       32'(es));
        check({tag, "_carry"}, 32'(bus4.carry),     32'(ec));
        check({tag, "_ovf"},   32'(bus4.overflow),  32'(eo));
        @(negedge clk);
        check({tag, "_drained"}, 32'(bus4.out_valid), 32'd0);
        check({tag, "_hold"},    32'(bus4.sum),       32'(es));
    endtask

    initial begin
        logic [17:0] sbq[$];
        logic [17:0] exp_v;
        int got;
        int sent;
        int seen;

        bus4.in_valid = 1'b0; bus4.out_ready = 1'b1; bus4.A = 16'h0000; bus4.B = 16'h0000;
        bus4.cin = 1'b0; bus4.sub = 1'b0;
        bus1.in_valid = 1'b0; bus1.out_ready = 1'b1; bus1.A = 8'h00; bus1.B = 8'h00;
        bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.A = 16'h0000; bus16.B = 16'h0000;
        bus16.cin = 1'b0; bus16.sub = 1'b0;

        // Reset state
        #3;
        check("rst_in_ready",  32'(bus4.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus4.out_valid), 32'd0);
        check("rst_sum",       32'(bus4.sum),       32'd0);
        check("rst_carry",     32'(bus4.carry),     32'd0);
        check("rst_ovf",       32'(bus4.overflow),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Directed vectors, hand-computed
        directed4("add_ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed4("add_7fff_c",  16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed4("sub_5_7",     16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed4("sub_8000_1",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed4("sub_10_3_b",  16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);

        // Stream of 10 beats with out_ready low for cycles 4..6
        got = 0; sent = 0;
        for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
            @(negedge clk);
            bus4.out_ready = !(cyc >= 4 && cyc <= 6);
            if (sent < 10) begin
                bus4.in_valid = 1'b1;
                bus4.A = 16'($urandom); bus4.B = 16'($urandom);
                bus4.cin = 1'($urandom); bus4.sub = 1'($urandom);
            end else begin
                bus4.in_valid = 1'b0;
            end
            #1;
            if (cyc == 3) check("stream_ready_3held", 32'(bus4.in_ready), 32'd1);
            if (cyc >= 4 && cyc <= 6) begin
                check("stream_full_ready", 32'(bus4.in_ready),  32'd0);
                check("stream_stall_vld",  32'(bus4.out_valid), 32'd1);
                if (sbq.size() > 0) begin
                    check("stream_stall_sum", 32'(bus4.sum),   32'(sbq[0][15:0]));
                    check("stream_stall_cy",  32'(bus4.carry), 32'(sbq[0][16]));
                end else begin
                    check("stream_stall_sb", 32'd0, 32'd1);
                end
            end
            if (bus4.out_valid && bus4.out_ready) begin
                if (sbq.size() > 0) begin
                    exp_v = sbq.pop_front();
                    check("stream_sum",   32'(bus4.sum),      32'(exp_v[15:0]));
                    check("stream_carry", 32'(bus4.carry),    32'(exp_v[16]));
                    check("stream_ovf",   32'(bus4.overflow), 32'(exp_v[17]));
                end else begin
                    check("stream_extra_beat", 32'd1, 32'd0);
                end
                got++;
            end
            if (bus4.in_valid && bus4.in_ready) begin
                sbq.push_back(model16(bus4.A, bus4.B, bus4.cin, bus4.sub));
                sent++;
            end
        end
        check("stream_count", 32'(got), 32'd10);

        // Load 3 beats, then reset between edges
        @(negedge clk);
        bus4.out_ready = 1'b0; bus4.in_valid = 1'b1;
        bus4.A = 16'h1234; bus4.B = 16'h1111; bus4.cin = 1'b0; bus4.sub = 1'b0;
        @(negedge clk);
        bus4.A = 16'h0001; bus4.B = 16'h0001;
        @(negedge clk);
        bus4.A = 16'h0002; bus4.B = 16'h0002;
        @(negedge clk);
        bus4.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", 32'(bus4.out_valid), 32'd1);
        check("pre_rst_sum",   32'(bus4.sum),       32'h2345);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus4.out_valid), 32'd0);
        check("mid_rst_sum",   32'(bus4.sum),       32'd0);
        check("mid_rst_ready", 32'(bus4.in_ready),  32'd1);
        @(negedge clk);
        rst = 1'b0;
        bus4.out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus4.out_valid) seen++;
        end
        check("post_rst_stale", 32'(seen), 32'd0);

        // Single-stage 8-bit unit
        @(negedge clk);
        bus1.A = 8'hC8; bus1.B = 8'h64; bus1.cin = 1'b0; bus1.sub = 1'b0;
        bus1.in_valid = 1'b1; bus1.out_ready = 1'b1;
        @(negedge clk);
        bus1.in_valid = 1'b0;
        check("s1_valid", 32'(bus1.out_valid), 32'd1);
        check("s1_sum",   32'(bus1.sum),       32'h2C);
        check("s1_carry", 32'(bus1.carry),     32'd1);
        check("s1_ovf",   32'(bus1.overflow),  32'd0);

        // 16-stage soak with random valid and backpressure
        sbq.delete();
        got = 0; sent = 0;
        for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
            @(negedge clk);
            bus16.out_ready = ($urandom_range(0, 9) < 7);
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                bus16.in_valid = 1'b1;
                bus16.A = 16'($urandom); bus16.B = 16'($urandom);
                bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
            end else begin
                bus16.in_valid = 1'b0;
            end
            #1;
            if (bus16.out_valid && bus16.out_ready) begin
                if (sbq.size() > 0) begin
                    exp_v = sbq.pop_front();
                    check("soak_result", {14'd0, bus16.overflow, bus16.carry, bus16.sum},
                          {14'd0, exp_v});
                end else begin
                    check("soak_extra_beat", 32'd1, 32'd0);
                end
                got++;
            end
            if (bus16.in_valid && bus16.in_ready) begin
                sbq.push_back(model16(bus16.A, bus16.B, bus16.cin, bus16.sub));
                sent++;
            end
        end
        check("soak_count", 32'(got), 32'd1000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
